// File: rtl/piano_sequencer.sv
// piano_sequencer: a single-divider tone generator for NUM_KEYS keys with two
// play modes.
//   lesson   (mode=0): sounds the lowest-indexed key whose switch is set.
//   autoplay (mode=1): walks a writable song memory of {end, dur, note} entries.
//                      Each entry lasts dur+1 beats and ends with a silent
//                      articulation gap. The walk stops or loops at an end
//                      entry, or after the last address.
// Ports:
//   CLK, RESET        system clock, asynchronous active-high reset
//   MODE              raw button (asynchronous); each rising edge toggles mode
//   LOOP              restart the song after its last entry instead of stopping
//   sw[NUM_KEYS]      lesson key switches
//   song_we/addr/wdata  song memory write port, {end, dur, note};
//                       note >= NUM_KEYS is a rest
//   FREQ              square-wave speaker output
//   key_idx, Led      sounding key index (4'hF = silent) and its one-hot LED
//   mode              1 = autoplay
//   song_ptr          entry being played
//   beat              one-cycle pulse per completed beat
//   done              song finished with LOOP=0
module piano_sequencer #(
  parameter int NUM_KEYS = 8,
  parameter int DIV_W = 18,
  parameter logic [NUM_KEYS*DIV_W-1:0] HALF_PERIODS = {
    18'd95557, 18'd101239, 18'd113636, 18'd127551,
    18'd143172, 18'd151686, 18'd170264, 18'd191110},
  parameter int BEAT_TICKS = 25000000,
  parameter int GAP_TICKS = 2500000,
  parameter int SONG_AW = 5,
  parameter int DUR_W = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MODE,
  input  logic                LOOP,
  input  logic [NUM_KEYS-1:0] sw,
  input  logic                song_we,
  input  logic [SONG_AW-1:0]  song_addr,
  input  logic [DUR_W+4:0]    song_wdata,
  output logic                FREQ,
  output logic [3:0]          key_idx,
  output logic [NUM_KEYS-1:0] Led,
  output logic                mode,
  output logic [SONG_AW-1:0]  song_ptr,
  output logic                beat,
  output logic                done
);

  localparam int DEPTH = 1 << SONG_AW;
  localparam int EW    = DUR_W + 5;
  localparam int TW    = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  // The note counter must reach (2**DUR_W)*BEAT_TICKS, the longest note.
  localparam int NW    = $clog2(longint'(2**DUR_W) * longint'(BEAT_TICKS) + 1);
  localparam logic [3:0] KEY_OFF = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_DONE} state_t;

  // ---------------------------------------------------------------- MODE sync
  // Two flops bring the button into the CLK domain. The third flop detects
  // the rising edge, so a held button gives exactly one toggle.
  logic [2:0] m_sync;
  logic       mode_rise;

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) m_sync <= '0;
    else       m_sync <= {m_sync[1:0], MODE};

  assign mode_rise = m_sync[1] & ~m_sync[2];

  // -------------------------------------------------------------- song memory
  // The memory has no reset, so the song survives RESET.
  logic [EW-1:0] song_mem [DEPTH];

  always_ff @(posedge CLK)
    if (song_we) song_mem[song_addr] <= song_wdata;

  // --------------------------------------------------------------- autoplay FSM
  state_t        state;
  logic [EW-1:0] ent;
  logic [TW-1:0] tick;
  logic [NW-1:0] ncnt;
  logic [3:0]    e_note;
  logic [DUR_W-1:0] e_dur;
  logic          e_end;
  logic [NW-1:0] note_len, snd_len;

  assign e_note   = ent[3:0];
  assign e_dur    = ent[DUR_W+3:4];
  assign e_end    = ent[DUR_W+4];
  assign note_len = (NW'(e_dur) + NW'(1)) * NW'(BEAT_TICKS);
  assign snd_len  = note_len - NW'(GAP_TICKS);

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state    <= S_IDLE;
      mode     <= 1'b0;
      song_ptr <= '0;
      tick     <= '0;
      ncnt     <= '0;
      ent      <= '0;
      beat     <= 1'b0;
      done     <= 1'b0;
    end else begin
      beat <= 1'b0;
      if (mode_rise) begin
        // A toggle overrides every state. Leaving lesson mode starts the
        // song from entry 0. Entering lesson mode parks the FSM in IDLE.
        mode     <= ~mode;
        state    <= mode ? S_IDLE : S_FETCH;
        song_ptr <= '0;
        tick     <= '0;
        ncnt     <= '0;
        done     <= 1'b0;
      end else begin
        case (state)
          S_FETCH: begin
            // A write to this address in the same cycle lands after the
            // read, so the fetch returns the old entry.
            ent   <= song_mem[song_ptr];
            tick  <= '0;
            ncnt  <= '0;
            state <= S_PLAY;
          end
          S_PLAY: begin
            beat <= (tick == TW'(BEAT_TICKS - 1));
            tick <= (tick == TW'(BEAT_TICKS - 1)) ? '0 : tick + TW'(1);
            if (ncnt == note_len - NW'(1)) begin
              ncnt <= '0;
              if (!e_end && song_ptr != {SONG_AW{1'b1}}) begin
                song_ptr <= song_ptr + SONG_AW'(1);
                state    <= S_FETCH;
              end else if (LOOP) begin
                song_ptr <= '0;
                state    <= S_FETCH;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              ncnt <= ncnt + NW'(1);
            end
          end
          default: ;  // IDLE and DONE wait for a mode toggle
        endcase
      end
    end

  // ------------------------------------------------------------ key selection
  logic [NUM_KEYS-1:0] sw_r;
  logic [3:0]          les_key, auto_key, nxt_key;
  logic [NUM_KEYS-1:0] nxt_led;

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) sw_r <= '0;
    else       sw_r <= sw;

  // The loop runs from the top key down, so the lowest set switch wins.
  always_comb begin
    les_key = KEY_OFF;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (sw_r[k]) les_key = 4'(k);
  end

  // Autoplay sounds only before the gap, and only for a real key.
  always_comb begin
    auto_key = KEY_OFF;
    if (state == S_PLAY && ncnt < snd_len && e_note < 4'(NUM_KEYS))
      auto_key = e_note;
  end

  assign nxt_key = mode ? auto_key : les_key;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_led
    assign nxt_led[k] = (nxt_key == 4'(k));
  end

  // ----------------------------------------------------------- tone generator
  logic [DIV_W-1:0] half, div;

  always_comb begin
    half = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (key_idx == 4'(k)) half = HALF_PERIODS[k*DIV_W +: DIV_W];
  end

  // A key change restarts the divider from 0 with FREQ low. The first rising
  // edge then comes a full half-period later, whatever the old phase was.
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      key_idx <= KEY_OFF;
      Led     <= '0;
      div     <= '0;
      FREQ    <= 1'b0;
    end else if (nxt_key != key_idx) begin
      key_idx <= nxt_key;
      Led     <= nxt_led;
      div     <= '0;
      FREQ    <= 1'b0;
    end else if (key_idx == KEY_OFF) begin
      div  <= '0;
      FREQ <= 1'b0;
    end else if (div == half - DIV_W'(1)) begin
      div  <= '0;
      FREQ <= ~FREQ;
    end else begin
      div <= div + DIV_W'(1);
    end

endmodule
